sc_mux_node: RTL and testbench



---
 rtl/sc_node_pkg.sv | 15 +
 rtl/sc_node_fifo.sv | 57 +++++
 rtl/sc_mux_node.sv | 140 ++++++++++++++
 tb/tb_sc_mux_node.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_node_pkg.sv
// Shared parameter defaults and helpers for the sc mux node family.
package sc_node_pkg;

  localparam int SC_NUM_SI_DEF   = 2;
  localparam int SC_PAYLD_W_DEF  = 174;
  localparam int SC_INFO_W_DEF   = 1;
  localparam int SC_DEPTH_DEF    = 4;
  localparam int SC_ARB_LOCK_DEF = 1;

  // Width of the grant index; a single-input node still gets a 1-bit port.
  function automatic int sc_grant_w(input int num_si);
    return (num_si > 1) ? $clog2(num_si) : 1;
  endfunction

endpackage

// File: rtl/sc_node_fifo.sv
// Single-input FIFO for the sc mux node. Head of queue is presented
// combinationally on rd_data; writes and reads may coincide at any
// fill level below full. The writer must never push while full and the
// reader must never pop while empty.
module sc_node_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array: written at the tail pointer.
  // NOTE: the data array has no reset; occupancy alone decides what is valid,
  // so clearing it would only cost flops and reset fanout.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sc_mux_node.sv
// N:1 sc mux node: per-SI FIFOs, round-robin arbiter with optional packet
// lock, and a single output register. A beat accepted at edge t is loaded
// into the output register at edge t+1 at the earliest.
module sc_mux_node
  import sc_node_pkg::*;
#(
  parameter int NUM_SI   = SC_NUM_SI_DEF,
  parameter int PAYLD_W  = SC_PAYLD_W_DEF,
  parameter int INFO_W   = SC_INFO_W_DEF,
  parameter int DEPTH    = SC_DEPTH_DEF,
  parameter int ARB_LOCK = SC_ARB_LOCK_DEF
) (
  input  logic                          sc_aclk,
  input  logic                          sc_aresetn,
  input  logic [NUM_SI*PAYLD_W-1:0]     s_sc_payld,
  input  logic [NUM_SI*INFO_W-1:0]      s_sc_info,
  input  logic [NUM_SI-1:0]             s_sc_req,
  input  logic [NUM_SI-1:0]             s_sc_send,
  output logic [NUM_SI-1:0]             s_sc_recv,
  output logic [PAYLD_W-1:0]            m_sc_payld,
  output logic [INFO_W-1:0]             m_sc_info,
  output logic                          m_sc_req,
  output logic                          m_sc_send,
  input  logic                          m_sc_recv,
  output logic [sc_grant_w(NUM_SI)-1:0] m_sc_grant
);

  localparam int GW    = sc_grant_w(NUM_SI);
  localparam int WIDTH = PAYLD_W + INFO_W;

  logic [NUM_SI-1:0] fifo_full;
  logic [NUM_SI-1:0] fifo_empty;
  logic [NUM_SI-1:0] fifo_wr;
  logic [NUM_SI-1:0] fifo_rd;
  logic [NUM_SI-1:0] nonempty;
  logic [NUM_SI-1:0] eligible;
  logic [WIDTH-1:0]  fifo_data [NUM_SI];

  logic [GW-1:0]     last_grant;
  logic              lock;
  logic [GW-1:0]     pick_idx;
  logic              pick_found;
  logic [WIDTH-1:0]  pick_data;
  logic              load_en;

  logic              out_valid;
  logic [PAYLD_W-1:0] out_payld;
  logic [INFO_W-1:0] out_info;
  logic [GW-1:0]     out_grant;

  // The per-SI request hint carries no function; fold it into a sink.
  logic req_hint_unused;
  assign req_hint_unused = ^s_sc_req;

  // Accept is forced low while reset is held so no beat slips in.
  assign s_sc_recv = ~fifo_full & {NUM_SI{sc_aresetn}};
  assign fifo_wr   = s_sc_send & s_sc_recv;
  assign nonempty  = ~fifo_empty;

  for (genvar k = 0; k < NUM_SI; k++) begin : g_si
    sc_node_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (sc_aclk),
      .rst_n   (sc_aresetn),
      .wr_en   (fifo_wr[k]),
      .wr_data ({s_sc_payld[k*PAYLD_W +: PAYLD_W], s_sc_info[k*INFO_W +: INFO_W]}),
      .rd_en   (fifo_rd[k]),
      .rd_data (fifo_data[k]),
      .full    (fifo_full[k]),
      .empty   (fifo_empty[k])
    );
    assign fifo_rd[k] = load_en && (pick_idx == GW'(k));
  end

  // SI index reached by stepping 'step' places past 'base', modulo NUM_SI.
  function automatic logic [GW-1:0] rr_slot(input logic [GW-1:0] base, input int step);
    return GW'((int'(base) + step) % NUM_SI);
  endfunction

  // While locked only the SI that opened the packet may be served; that SI
  // is always last_grant because the lock is taken on its own load.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    eligible = nonempty;
    if (lock) eligible = nonempty & (NUM_SI'(1) << last_grant);
  end

  // Round-robin search from last_grant+1; the nearest eligible SI wins,
  // so the loop runs farthest-first and lets closer hits overwrite.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_SI; i >= 1; i--) begin
      if (eligible[rr_slot(last_grant, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_slot(last_grant, i);
      end
    end
  end

  assign pick_data = fifo_data[pick_idx];
  assign load_en   = pick_found && (!out_valid || m_sc_recv);

  // Arbiter state: remember the winner and open/close the packet lock.
  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      last_grant <= GW'(NUM_SI - 1);
      lock       <= 1'b0;
    end else if (load_en) begin
      last_grant <= pick_idx;
      lock       <= (ARB_LOCK != 0) && !pick_data[0];
    end
  end

  // Output register: load when empty or being drained, otherwise hold.
  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      out_valid <= 1'b0;
      out_payld <= '0;
      out_info  <= '0;
      out_grant <= '0;
    end else if (load_en) begin
      out_valid              <= 1'b1;
      {out_payld, out_info}  <= pick_data;
      out_grant              <= pick_idx;
    end else if (m_sc_recv) begin
      out_valid <= 1'b0;
    end
  end

  assign m_sc_send  = out_valid;
  assign m_sc_payld = out_payld;
  assign m_sc_info  = out_info;
  assign m_sc_grant = out_grant;
  assign m_sc_req   = (|nonempty) | out_valid;

endmodule

// File: tb/tb_sc_mux_node.sv
// Randomised and directed bench for sc_mux_node with a per-SI scoreboard
// and a transaction-level arbitration model.
module tb_sc_mux_node;

  localparam int N  = 3;
  localparam int PW = 32;
  localparam int IW = 1;
  localparam int D  = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*PW-1:0] s_payld = '0;
  logic [N*IW-1:0] s_info = '0;
  logic [N-1:0]    s_req = '0;
  logic [N-1:0]    s_send = '0;
  logic [N-1:0]    s_recv;
  logic [PW-1:0]   m_payld;
  logic [IW-1:0]   m_info;
  logic            m_req;
  logic            m_send;
  logic            m_recv = 1'b0;
  logic [GW-1:0]   m_grant;

  always #5 clk = ~clk;

  sc_mux_node #(
    .NUM_SI(N), .PAYLD_W(PW), .INFO_W(IW), .DEPTH(D), .ARB_LOCK(1)
  ) dut (
    .sc_aclk    (clk),
    .sc_aresetn (rst_n),
    .s_sc_payld (s_payld),
    .s_sc_info  (s_info),
    .s_sc_req   (s_req),
    .s_sc_send  (s_send),
    .s_sc_recv  (s_recv),
    .m_sc_payld (m_payld),
    .m_sc_info  (m_info),
    .m_sc_req   (m_req),
    .m_sc_send  (m_send),
    .m_sc_recv  (m_recv),
    .m_sc_grant (m_grant)
  );

  typedef struct {
    int            acc;    // edge at which the beat entered the node
    logic [PW-1:0] payld;
    logic [IW-1:0] info;
  } beat_t;

  beat_t exp_q [N][$];
  int    grant_log [$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    edge_cnt = 0;
  int    seq [N];
  int    acc_cnt [N];

  // Reference arbitration state (transaction level).
  int            last_grant = N - 1;
  bit            locked = 1'b0;
  bit            prev_send = 1'b0;
  int            lock_bubbles = 0;
  logic [PW-1:0] held_payld = '0;
  logic [IW-1:0] held_info = '0;
  int            held_grant = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A beat is loadable at this edge if it entered the FIFO at an earlier edge.
  function automatic bit head_ready(input int k);
    return (exp_q[k].size() > 0) && (exp_q[k][0].acc < edge_cnt);
  endfunction

  // Monitor: after each edge decide what the node should present.
  initial begin : monitor
    bit    could_load, exp_send, found, blocked, any_held;
    int    pick, cand;
    beat_t b;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_send  = 1'b0;
        last_grant = N - 1;
        locked     = 1'b0;
        continue;
      end
      could_load = !prev_send || m_recv;
      found = 1'b0; blocked = 1'b0; pick = 0;
      if (could_load) begin
        if (locked) begin
          if (head_ready(last_grant)) begin
            found = 1'b1;
            pick  = last_grant;
          end else begin
            for (int k = 0; k < N; k++) if (head_ready(k)) blocked = 1'b1;
          end
        end else begin
          for (int i = 1; i <= N; i++) begin
            cand = (last_grant + i) % N;
            if (head_ready(cand)) begin
              found = 1'b1;
              pick  = cand;
              break;
            end
          end
        end
      end
      if (found) begin
        b          = exp_q[pick].pop_front();
        held_payld = b.payld;
        held_info  = b.info;
        held_grant = pick;
        last_grant = pick;
        locked     = !b.info[0];
        grant_log.push_back(pick);
        exp_send   = 1'b1;
      end else if (could_load) begin
        exp_send = 1'b0;
        if (blocked) lock_bubbles++;
      end else begin
        exp_send = 1'b1;
      end
      check("m_sc_send", m_send, exp_send);
      if (exp_send) begin
        check("m_sc_payld", m_payld, held_payld);
        check("m_sc_info", m_info, held_info);
        check("m_sc_grant", m_grant, held_grant);
      end
      any_held = exp_send;
      for (int k = 0; k < N; k++) if (exp_q[k].size() > 0) any_held = 1'b1;
      check("m_sc_req", m_req, any_held);
      prev_send = exp_send;
    end
  end

  // One stimulus cycle: check accept flags, then present new inputs.
  task automatic drive_cycle(input logic [N-1:0] snd, input logic [N-1:0] inf, input logic rcv);
    bit    er;
    beat_t b;
    @(posedge clk); #2;
    m_recv = rcv;
    s_req  = N'($urandom);
    for (int k = 0; k < N; k++) begin
      er = rst_n && (exp_q[k].size() < D);
      check("s_sc_recv", s_recv[k], er);
      s_send[k] = snd[k];
      s_info[k] = inf[k];
      s_payld[k*PW +: PW] = {8'(k), 24'(seq[k])};
      if (snd[k] && er) begin
        b.acc   = edge_cnt + 1;
        b.payld = {8'(k), 24'(seq[k])};
        b.info  = inf[k];
        exp_q[k].push_back(b);
        seq[k]++;
        acc_cnt[k]++;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle('0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_send", m_send, 0);
    check("rst_req", m_req, 0);
    check("rst_recv", s_recv, 0);
    s_send = '0;
    m_recv = 1'b0;
    for (int k = 0; k < N; k++) exp_q[k].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_recv", s_recv, {N{1'b1}});
    check("post_rst_req", m_req, 0);
    check("post_rst_send", m_send, 0);
  endtask

  initial begin : watchdog
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : main
    int first1, run, total, lb0;
    int fair_exp [6];
    fair_exp = '{0, 1, 2, 0, 1, 2};
    for (int k = 0; k < N; k++) begin seq[k] = 0; acc_cnt[k] = 0; end

    // Power-on reset.
    #1;
    check("init_send", m_send, 0);
    check("init_req", m_req, 0);
    check("init_grant", m_grant, 0);
    check("init_recv", s_recv, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("init_rel_recv", s_recv, {N{1'b1}});

    // Single beat 0x5A from SI0: visible after the second edge, not the first.
    seq[0] = 32'h5A;
    drive_cycle(3'b001, 3'b001, 1'b1);
    drive_cycle('0, '0, 1'b1);
    check("single_not_early", m_send, 0);
    drive_cycle('0, '0, 1'b1);
    check("single_send", m_send, 1);
    check("single_payld", m_payld, 32'h5A);
    check("single_grant", m_grant, 0);
    idle(4);

    // Fairness: all SIs streaming single-beat packets straight after reset.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 12; i++) drive_cycle(3'b111, 3'b111, 1'b1);
    idle(12);
    check("fair_count", grant_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) check("fair_order", grant_log[i], fair_exp[i]);

    // Backpressure: FIFO plus output register absorb exactly DEPTH+1 beats.
    acc_cnt[0] = 0;
    for (int i = 0; i < 8; i++) drive_cycle(3'b001, 3'b001, 1'b0);
    check("bp_accepted", acc_cnt[0], D + 1);
    check("bp_recv_low", s_recv[0], 0);
    check("bp_send_held", m_send, 1);
    idle(10);
    total = 0;
    for (int k = 0; k < N; k++) total += exp_q[k].size();
    check("bp_drained", total, 0);

    // Lock: SI1 packet info 0,0,0,1 with a two-cycle gap, SI0 streaming.
    grant_log.delete();
    lb0 = lock_bubbles;
    for (int i = 0; i < 3; i++) drive_cycle(3'b001, 3'b001, 1'b1);
    drive_cycle(3'b011, 3'b001, 1'b1);
    drive_cycle(3'b011, 3'b001, 1'b1);
    drive_cycle(3'b001, 3'b001, 1'b1);
    drive_cycle(3'b001, 3'b001, 1'b1);
    drive_cycle(3'b011, 3'b001, 1'b1);
    drive_cycle(3'b011, 3'b011, 1'b1);
    for (int i = 0; i < 6; i++) drive_cycle(3'b001, 3'b001, 1'b1);
    idle(10);
    check("lock_bubbles", lock_bubbles - lb0, 2);
    first1 = -1;
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] == 1) begin first1 = i; break; end
    check("lock_found", first1 >= 0, 1);
    run = 0;
    if (first1 >= 0)
      for (int i = first1; i < grant_log.size(); i++) begin
        if (grant_log[i] != 1) break;
        run++;
      end
    check("lock_run", run, 4);
    if (first1 >= 0 && first1 + 4 < grant_log.size())
      check("lock_after", grant_log[first1 + 4], 0);

    // Random traffic with random backpressure and random packet framing.
    for (int i = 0; i < 300; i++)
      drive_cycle(N'($urandom), N'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10; i++) drive_cycle(3'b111, 3'b111, 1'b1);
    idle(30);
    total = 0;
    for (int k = 0; k < N; k++) total += exp_q[k].size();
    check("rand_drained", total, 0);
    check("rand_req_idle", m_req, 0);

    // Reset with three beats held (one in output, two queued).
    for (int i = 0; i < 3; i++) drive_cycle(3'b001, 3'b001, 1'b0);
    drive_cycle('0, '0, 1'b0);
    check("mid_send_before", m_send, 1);
    check("mid_req_before", m_req, 1);
    do_reset();
    grant_log.delete();
    drive_cycle(3'b011, 3'b011, 1'b1);
    idle(4);
    check("mid_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("mid_first_grant", grant_log[0], 0);
      check("mid_second_grant", grant_log[1], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
